// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: clear control, write port and two read ports.
// The sequencer side uses the master modport, the register file the slave modport.
interface reg_file_mp_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
);
    logic              clr_req;
    logic              busy;
    logic              wr_addr_ld;
    logic [ADDR_W-1:0] wr_sel;
    logic              wr_en;
    logic              wr_auto_inc;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_ptr;
    logic              rd_en_a;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic              rd_en_b;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;

    modport master (
        output clr_req, wr_addr_ld, wr_sel, wr_en, wr_auto_inc, wr_data,
        output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        input  busy, wr_ptr, rd_data_a, rd_data_b
    );

    modport slave (
        input  clr_req, wr_addr_ld, wr_sel, wr_en, wr_auto_inc, wr_data,
        input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        output busy, wr_ptr, rd_data_a, rd_data_b
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file: one write port with a latched, optionally auto-incrementing
// write pointer, two registered read ports, and a clear sequencer that zeroes the array
// after reset or on request.
// Optional feature: define REGFILE_BYPASS_EN for write-first forwarding on a same-cycle
// read/write collision; otherwise collisions return the old content (read-first).
module reg_file_mp #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
) (
    input logic           clk,
    input logic           rst_n,
    reg_file_mp_if.slave  bus_io
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
    logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              idle;
    logic [ADDR_W-1:0] wr_eff;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign idle   = (state_q == StIdle);
    assign wr_eff = bus_io.wr_addr_ld ? bus_io.wr_sel : wr_ptr_q;

    // Clear sequencer next state: one entry zeroed per cycle, DEPTH cycles in total.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            StIdle: begin
                if (bus_io.clr_req) begin
                    state_d   = StClear;
                    clr_idx_d = '0;
                end
            end
            StClear: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Array write source: the sequencer owns the write port while clearing.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_eff;
        mem_wdata = bus_io.wr_data;
        if (state_q == StClear) begin
            mem_we    = 1'b1;
            mem_waddr = clr_idx_q;
            mem_wdata = '0;
        end else if (bus_io.wr_en) begin
            mem_we = 1'b1;
        end
    end

    // Write pointer: auto-increment after a write wins over a plain load.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (idle) begin
            if (bus_io.wr_en && bus_io.wr_auto_inc) begin
                wr_ptr_d = wr_eff + 1'b1;
            end else if (bus_io.wr_addr_ld) begin
                wr_ptr_d = bus_io.wr_sel;
            end
        end
    end

    // Read ports: load 0 while clearing, otherwise array content (or forwarded write data).
    always_comb begin
        rd_data_a_d = rd_data_a_q;
        rd_data_b_d = rd_data_b_q;
        if (bus_io.rd_en_a) begin
            if (!idle) begin
                rd_data_a_d = '0;
            end else begin
                rd_data_a_d = mem_q[bus_io.rd_addr_a];
`ifdef REGFILE_BYPASS_EN
                if (bus_io.wr_en && (wr_eff == bus_io.rd_addr_a)) begin
                    rd_data_a_d = bus_io.wr_data;
                end
`endif
            end
        end
        if (bus_io.rd_en_b) begin
            if (!idle) begin
                rd_data_b_d = '0;
            end else begin
                rd_data_b_d = mem_q[bus_io.rd_addr_b];
`ifdef REGFILE_BYPASS_EN
                if (bus_io.wr_en && (wr_eff == bus_io.rd_addr_b)) begin
                    rd_data_b_d = bus_io.wr_data;
                end
`endif
            end
        end
    end

    // Control and output registers; reset restarts the clear at index 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StClear;
            clr_idx_q   <= '0;
            wr_ptr_q    <= '0;
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
        end
    end

    // Storage array; no reset, the clear sequencer zeroes it instead.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bus_io.busy      = (state_q == StClear);
    assign bus_io.wr_ptr    = wr_ptr_q;
    assign bus_io.rd_data_a = rd_data_a_q;
    assign bus_io.rd_data_b = rd_data_b_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: a bench-side model of the array and write pointer
// supplies expected read data, pushed to per-port queues when a read is issued and popped
// when the registered result appears.
module tb_reg_file_mp;
    logic clk;
    logic rst_n;

    reg_file_mp_if #(.DATA_W(8), .ADDR_W(5)) bus ();

    reg_file_mp #(.DATA_W(8), .ADDR_W(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         errors;
    int         checks;
    logic [7:0] model_mem [32];
    logic [4:0] model_ptr;
    logic [7:0] q_a [$];
    logic [7:0] q_b [$];
    logic [7:0] exp_a;
    logic [7:0] exp_b;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.clr_req     = 1'b0;
        bus.wr_addr_ld  = 1'b0;
        bus.wr_sel      = '0;
        bus.wr_en       = 1'b0;
        bus.wr_auto_inc = 1'b0;
        bus.wr_data     = '0;
        bus.rd_en_a     = 1'b0;
        bus.rd_addr_a   = '0;
        bus.rd_en_b     = 1'b0;
        bus.rd_addr_b   = '0;
    endtask

    task automatic model_zero();
        for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;
    endtask

    // One idle-state write-port cycle; the model tracks array and pointer.
    task automatic do_write(input bit en, input bit ld, input bit inc,
                            input logic [4:0] sel, input logic [7:0] data);
        logic [4:0] eff;
        eff = ld ? sel : model_ptr;
        bus.wr_en       = en;
        bus.wr_addr_ld  = ld;
        bus.wr_auto_inc = inc;
        bus.wr_sel      = sel;
        bus.wr_data     = data;
        step();
        if (en) model_mem[eff] = data;
        if (en && inc) model_ptr = eff + 5'd1;
        else if (ld) model_ptr = sel;
        idle_inputs();
    endtask

    task automatic issue_read(input bit ena, input logic [4:0] aa, input bit enb,
                              input logic [4:0] ab);
        bus.rd_en_a   = ena;
        bus.rd_addr_a = aa;
        bus.rd_en_b   = enb;
        bus.rd_addr_b = ab;
        if (ena) q_a.push_back(model_mem[aa]);
        if (enb) q_b.push_back(model_mem[ab]);
        step();
        bus.rd_en_a = 1'b0;
        bus.rd_en_b = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL reset_busy: got %b want 1", bus.busy);
        end
        checks++;
        if (bus.rd_data_a !== 8'h00 || bus.rd_data_b !== 8'h00) begin
            errors++;
            $display("FAIL reset_rd_data: got %h/%h want 00/00", bus.rd_data_a, bus.rd_data_b);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            checks++;
            if (bus.busy !== 1'(k < 32)) begin
                errors++; $display("FAIL reset_busy_len[%0d]: got %b want %b", k, bus.busy, k < 32);
            end
        end
        model_zero();
        model_ptr = '0;
        checks++;
        if (bus.wr_ptr !== model_ptr) begin
            errors++; $display("FAIL reset_wr_ptr: got %0d want %0d", bus.wr_ptr, model_ptr);
        end
        for (int i = 0; i < 32; i++) begin
            issue_read(1'b1, 5'(i), 1'b1, 5'(31 - i));
            exp_a = q_a.pop_front();
            exp_b = q_b.pop_front();
            checks++;
            if (bus.rd_data_a !== exp_a || bus.rd_data_b !== exp_b) begin
                errors++;
                $display("FAIL reset_read[%0d]: got %h/%h want %h/%h",
                         i, bus.rd_data_a, bus.rd_data_b, exp_a, exp_b);
            end
        end
    endtask

    task automatic test_write_read();
        do_write(1'b1, 1'b1, 1'b1, 5'd5, 8'hA5);
        checks++;
        if (bus.wr_ptr !== 5'd6) begin
            errors++; $display("FAIL wr_ptr_after_inc: got %0d want 6", bus.wr_ptr);
        end
        issue_read(1'b1, 5'd5, 1'b0, 5'd0);
        exp_a = q_a.pop_front();
        checks++;
        if (bus.rd_data_a !== exp_a) begin
            errors++; $display("FAIL read_a_5: got %h want %h", bus.rd_data_a, exp_a);
        end
        // rd_en low: output must hold while the entry changes underneath
        do_write(1'b1, 1'b1, 1'b0, 5'd5, 8'h5A);
        checks++;
        if (bus.rd_data_a !== exp_a) begin
            errors++; $display("FAIL read_a_hold: got %h want %h", bus.rd_data_a, exp_a);
        end
        issue_read(1'b0, 5'd0, 1'b1, 5'd5);
        exp_b = q_b.pop_front();
        checks++;
        if (bus.rd_data_b !== exp_b) begin
            errors++; $display("FAIL read_b_5: got %h want %h", bus.rd_data_b, exp_b);
        end
    endtask

    task automatic test_wrap();
        do_write(1'b0, 1'b1, 1'b0, 5'd31, 8'h00);
        checks++;
        if (bus.wr_ptr !== 5'd31) begin
            errors++; $display("FAIL wr_ptr_load: got %0d want 31", bus.wr_ptr);
        end
        do_write(1'b1, 1'b0, 1'b1, 5'd0, 8'h3C);
        checks++;
        if (bus.wr_ptr !== 5'd0) begin
            errors++; $display("FAIL wr_ptr_wrap: got %0d want 0", bus.wr_ptr);
        end
        issue_read(1'b1, 5'd31, 1'b1, 5'd31);
        exp_a = q_a.pop_front();
        exp_b = q_b.pop_front();
        checks++;
        if (bus.rd_data_a !== exp_a || bus.rd_data_b !== exp_b) begin
            errors++;
            $display("FAIL read_31: got %h/%h want %h/%h",
                     bus.rd_data_a, bus.rd_data_b, exp_a, exp_b);
        end
    endtask

    task automatic test_collision();
        logic [7:0] coll;
        do_write(1'b1, 1'b1, 1'b0, 5'd7, 8'h11);
`ifdef REGFILE_BYPASS_EN
        coll = 8'h22;
`else
        coll = model_mem[7];
`endif
        bus.wr_en      = 1'b1;
        bus.wr_addr_ld = 1'b1;
        bus.wr_sel     = 5'd7;
        bus.wr_data    = 8'h22;
        bus.rd_en_a    = 1'b1;
        bus.rd_addr_a  = 5'd7;
        bus.rd_en_b    = 1'b1;
        bus.rd_addr_b  = 5'd7;
        q_a.push_back(coll);
        q_b.push_back(coll);
        step();
        model_mem[7] = 8'h22;
        model_ptr    = 5'd7;
        idle_inputs();
        exp_a = q_a.pop_front();
        exp_b = q_b.pop_front();
        checks++;
        if (bus.rd_data_a !== exp_a || bus.rd_data_b !== exp_b) begin
            errors++;
            $display("FAIL collision: got %h/%h want %h/%h",
                     bus.rd_data_a, bus.rd_data_b, exp_a, exp_b);
        end
        issue_read(1'b1, 5'd7, 1'b1, 5'd7);
        exp_a = q_a.pop_front();
        exp_b = q_b.pop_front();
        checks++;
        if (bus.rd_data_a !== exp_a || bus.rd_data_b !== exp_b) begin
            errors++;
            $display("FAIL after_collision: got %h/%h want %h/%h",
                     bus.rd_data_a, bus.rd_data_b, exp_a, exp_b);
        end
    endtask

    task automatic test_clear();
        logic [4:0] ptr_hold;
        do_write(1'b1, 1'b1, 1'b1, 5'd0, 8'hFF);
        for (int i = 1; i < 32; i++) do_write(1'b1, 1'b0, 1'b1, 5'd0, 8'hFF);
        ptr_hold = model_ptr;
        bus.clr_req = 1'b1;
        step();
        for (int k = 1; k <= 32; k++) begin
            checks++;
            if (bus.busy !== 1'b1) begin
                errors++; $display("FAIL clear_busy[%0d]: got %b want 1", k, bus.busy);
            end
            // Junk traffic during the first cycles of the clear must be ignored
            if (k <= 10) begin
                bus.clr_req    = 1'b1;
                bus.wr_en      = 1'b1;
                bus.wr_addr_ld = 1'b1;
                bus.wr_sel     = 5'd3;
                bus.wr_data    = 8'h55;
                bus.rd_en_a    = 1'b1;
                bus.rd_addr_a  = 5'd20;
            end else begin
                idle_inputs();
            end
            step();
            if (k == 1) begin
                checks++;
                if (bus.rd_data_a !== 8'h00) begin
                    errors++; $display("FAIL clear_read_zero: got %h want 00", bus.rd_data_a);
                end
            end
        end
        idle_inputs();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL clear_done: got busy=%b want 0", bus.busy);
        end
        checks++;
        if (bus.wr_ptr !== ptr_hold) begin
            errors++; $display("FAIL clear_wr_ptr_hold: got %0d want %0d", bus.wr_ptr, ptr_hold);
        end
        step();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL clear_req_ignored: got busy=%b want 0", bus.busy);
        end
        model_zero();
        for (int i = 0; i < 32; i++) begin
            issue_read(1'b1, 5'(i), 1'b1, 5'(31 - i));
            exp_a = q_a.pop_front();
            exp_b = q_b.pop_front();
            checks++;
            if (bus.rd_data_a !== exp_a || bus.rd_data_b !== exp_b) begin
                errors++;
                $display("FAIL clear_read[%0d]: got %h/%h want %h/%h",
                         i, bus.rd_data_a, bus.rd_data_b, exp_a, exp_b);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        do_write(1'b1, 1'b1, 1'b1, 5'd2, 8'h77);
        do_write(1'b1, 1'b0, 1'b0, 5'd0, 8'h99);
        issue_read(1'b1, 5'd2, 1'b1, 5'd2);
        exp_a = q_a.pop_front();
        exp_b = q_b.pop_front();
        checks++;
        if (bus.rd_data_a !== exp_a || bus.rd_data_b !== exp_b) begin
            errors++;
            $display("FAIL pre_reset_read: got %h/%h want %h/%h",
                     bus.rd_data_a, bus.rd_data_b, exp_a, exp_b);
        end
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        for (int k = 0; k < 10; k++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        model_ptr = '0;
        checks++;
        if (bus.busy !== 1'b1 || bus.wr_ptr !== model_ptr) begin
            errors++;
            $display("FAIL midclr_reset: got busy=%b ptr=%0d want 1/0", bus.busy, bus.wr_ptr);
        end
        checks++;
        if (bus.rd_data_a !== 8'h00 || bus.rd_data_b !== 8'h00) begin
            errors++;
            $display("FAIL midclr_rd_zero: got %h/%h want 00/00", bus.rd_data_a, bus.rd_data_b);
        end
        for (int k = 1; k <= 32; k++) begin
            step();
            checks++;
            if (bus.busy !== 1'(k < 32)) begin
                errors++;
                $display("FAIL midclr_busy_len[%0d]: got %b want %b", k, bus.busy, k < 32);
            end
        end
        model_zero();
        for (int i = 0; i < 32; i++) begin
            issue_read(1'b1, 5'(i), 1'b1, 5'(31 - i));
            exp_a = q_a.pop_front();
            exp_b = q_b.pop_front();
            checks++;
            if (bus.rd_data_a !== exp_a || bus.rd_data_b !== exp_b) begin
                errors++;
                $display("FAIL midclr_read[%0d]: got %h/%h want %h/%h",
                         i, bus.rd_data_a, bus.rd_data_b, exp_a, exp_b);
            end
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        model_ptr = '0;
        model_zero();
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_write_read();
        test_wrap();
        test_collision();
        test_clear();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
